// File: rtl/delay_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_sched_if
// Description : Configuration, control and data bundle for delay_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_sched_if #(
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    parameter int DW    = 1
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LW = c_AW + 1;

    logic            cfg_we;
    logic [c_AW-1:0] cfg_addr;
    logic [CW-1:0]   cfg_delay;
    logic [c_LW-1:0] cfg_len;
    logic            mode;
    logic            start;
    logic            abort;
    logic [DW-1:0]   din;
    logic [DW-1:0]   dout;
    logic            busy;
    logic            done;
    logic [c_AW-1:0] step_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_delay, cfg_len, mode, start, abort, din,
        input  dout, busy, done, step_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_delay, cfg_len, mode, start, abort, din,
        output dout, busy, done, step_idx
    );
endinterface
`default_nettype wire

// File: rtl/delay_sched.sv
`default_nettype none
// ============================================================================
// Module      : delay_sched
// Description : Programmable sample-and-apply sequencer driven by a table of
//               per-step delays (general and embedded sampling modes).
// Revision    : 1.0 - initial release
// ============================================================================
module delay_sched #(
    parameter int            DEPTH   = 4,
    parameter int            CW      = 8,
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = '1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    delay_sched_if.slave bus
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LW = c_AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_table [DEPTH];
    logic [CW-1:0]   r_cnt;
    logic [c_AW-1:0] r_idx;
    logic [c_LW-1:0] r_len;
    logic            r_mode;
    logic [DW-1:0]   r_held;
    logic [DW-1:0]   r_dout;
    logic            r_busy;
    logic            r_done;

    logic            w_len_ok;
    logic            w_last;
    logic            w_apply;
    logic [c_AW-1:0] w_idx_nxt;

    // A zero delay entry still occupies one cycle.
    function automatic logic [CW-1:0] f_eff(input logic [CW-1:0] d);
        return (d == '0) ? CW'(1) : d;
    endfunction

    assign w_len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= c_LW'(DEPTH));
    assign w_last    = ({1'b0, r_idx} == (r_len - c_LW'(1)));
    assign w_apply   = (r_cnt == CW'(1));
    assign w_idx_nxt = r_idx + c_AW'(1);

    // Entry table has no reset and is frozen while a schedule runs.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.cfg_we) begin
            r_table[bus.cfg_addr] <= bus.cfg_delay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_mode  <= 1'b0;
            r_held  <= '0;
            r_dout  <= RST_VAL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && w_len_ok) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_mode  <= bus.mode;
                        r_len   <= bus.cfg_len;
                        r_cnt   <= f_eff(r_table[0]);
                        r_idx   <= '0;
                        if (bus.mode) begin
                            r_held <= bus.din;
                        end
                    end
                end
                RUN: begin
                    // Abort takes priority over a coincident step completion.
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_held  <= '0;
                    end else if (w_apply) begin
                        r_dout <= r_mode ? r_held : bus.din;
                        if (r_mode) begin
                            r_held <= bus.din;
                        end
                        if (w_last) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= w_idx_nxt;
                            r_cnt <= f_eff(r_table[w_idx_nxt]);
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout     = r_dout;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.step_idx = r_idx;
endmodule
`default_nettype wire

// File: doc/delay_sched.md
# delay_sched

Programmable sample-and-apply sequencer that updates a held output from a data input at a configured list of cycle offsets. It is the synthesizable counterpart of the timing-control experiments in this section. Mode 0 (general) waits, then samples and applies. Mode 1 (embedded) samples at the start of each step and applies that sample when the step's delay expires. It sits between a signal source and any consumer that needs values captured on a schedule, and is configured over a simple write port.

## Interface
- DEPTH, 4: number of schedule entries (2..16)
- CW, 8: delay counter width; max delay 2^CW-1 cycles
- DW, 1: data width of din/dout
- RST_VAL, all ones: reset/initial value of dout
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- cfg_we  input  1  write cfg_delay into entry cfg_addr
- cfg_addr  input  $clog2(DEPTH)  entry index
- cfg_delay  input  CW  step delay in cycles (0 treated as 1)
- cfg_len  input  $clog2(DEPTH)+1  number of steps to run (1..DEPTH), sampled at start
- mode  input  1  0 = general, 1 = embedded; sampled at start
- start  input  1  single-cycle request to run the schedule
- abort  input  1  synchronous stop
- din  input  DW  value being sampled
- dout  output  DW  scheduled output, registered
- busy  output  1  schedule running
- done  output  1  one-cycle pulse after the last step is applied
- step_idx  output  $clog2(DEPTH)  index of the current step

## Operation
- FSM states: IDLE, RUN.
- IDLE: cfg_we writes the entry. start with cfg_len in 1..DEPTH latches mode and len, loads cnt=max(delay[0],1) and idx=0, then goes to RUN. In mode 1 it also latches held=din. A start with cfg_len=0 or cfg_len>DEPTH is ignored.
- RUN: cnt decrements every cycle. The step completes on the edge where cnt==1:
  - mode 0: dout<=din (the value present at that edge).
  - mode 1: dout<=held, and held<=din (the sample for the next step).
  - If idx==len-1: done=1 and the FSM goes to IDLE. Otherwise idx++ and cnt<=max(delay[idx+1],1).
- In RUN, start and cfg_we are ignored; the entry table is not modified.
- abort in RUN: return to IDLE next edge with no done pulse. dout keeps its last value and held is discarded. abort in IDLE has no effect.
- abort and step completion on the same edge: abort wins, dout is not updated, and there is no done pulse.
- The entry table has no reset; its contents are undefined until written. The FSM, cnt, idx, held and all outputs reset.

## Timing
- Reset values: dout=RST_VAL, busy=0, done=0, step_idx=0, FSM=IDLE, held=0.
- An asynchronous assert of rst_n mid-run forces the reset values immediately. Operation resumes only after a new start following deassertion.
- Offsets are measured from the start edge T0. Step k applies at T0+sum(max(delay[0..k],1)), so offsets are cumulative.
- busy goes high the cycle after the start edge and low the cycle after the edge that applies the last step.
- done is high for exactly one cycle, the cycle after the last apply edge, coincident with busy falling.
- A new start is accepted in the cycle done is high (the FSM is already IDLE), which allows back-to-back runs with no gap cycle.
- step_idx equals idx. It is stable during each step's countdown and returns to 0 in IDLE.
- Mode 1 latency: the value applied at step k was sampled at the apply edge of step k-1, or at T0 for k=0.
- dout changes only on apply edges and at reset.

## Test plan
- General mode:
  - Setup: delays {10,45,30,20}, len=4, mode 0. din drives 0, becomes 1 at cycle 25, 0 at 60, 1 at 100, 0 at 110 (relative to T0).
  - Required: dout=1 before cycle 10, then 0 at 10, 1 at 55, 0 at 85, 1 at 105. done pulses at 106.
- Embedded mode:
  - Setup: same delays and din waveform, mode 1.
  - Required: dout=0 at 10 (sampled at T0), 0 at 55 (sampled at 10), 1 at 85 (sampled at 55), 0 at 105 (sampled at 85).
- Boundaries: a delay entry of 0 behaves as 1; len=1 gives done one cycle after the single apply; start with len=0 leaves busy=0.
- Abort:
  - Abort at cycle 30 of the general run: busy=0 at 31, dout holds 0, no done pulse.
  - Abort on the exact apply edge at cycle 55: dout stays 0 and no step is applied.
- Ignored inputs in RUN: start and cfg_we asserted during a run leave the schedule and entry table unchanged (verified by a re-run). A start during the done cycle begins a new run immediately.
- Reset mid-run: rst_n low at cycle 40 immediately gives dout=RST_VAL and busy=0. After release, there is no activity until the next start.
